// File: rtl/proc_run_ctrl.sv
// Run controller for the processor core: stretched core reset, free-run or
// single-step clock enable, halt/watchdog stop and a saturating cycle counter.
module proc_run_ctrl #(
    parameter int CNT_W      = 32,
    parameter int RST_CYCLES = 4,
    parameter int TIMEOUT    = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    input  logic             halt_in,
    output logic             core_rst_n,
    output logic             core_en,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_cnt
);

    typedef enum logic [2:0] {
        HOLD,
        IDLE,
        RUN,
        STEP_WAIT,
        HALTED
    } state_t;

    localparam int HW = $clog2(RST_CYCLES + 1);
    localparam logic [HW-1:0]    HOLD_LAST = HW'(RST_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] WD_LAST   = CNT_W'(TIMEOUT - 1);
    localparam bit               WD_ON     = (TIMEOUT > 0);

    state_t           state, state_n;
    logic [HW-1:0]    hold_cnt, hold_n;
    logic             rst_n_n, en_n, busy_n, done_n, to_n;
    logic [CNT_W-1:0] cnt_n, cnt_inc;
    logic             stop_halt, stop_wd;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= HOLD;
            hold_cnt   <= '0;
            core_rst_n <= 1'b0;
            core_en    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            cycle_cnt  <= '0;
        end else begin
            state      <= state_n;
            hold_cnt   <= hold_n;
            core_rst_n <= rst_n_n;
            core_en    <= en_n;
            busy       <= busy_n;
            done       <= done_n;
            timeout    <= to_n;
            cycle_cnt  <= cnt_n;
        end
    end

    // Stop conditions only apply to a cycle in which the core actually ran.
    always_comb begin
        cnt_inc   = (cycle_cnt == CNT_MAX) ? cycle_cnt : cycle_cnt + 1'b1;
        stop_halt = core_en & halt_in;
        stop_wd   = core_en & ~halt_in & WD_ON & (cycle_cnt == WD_LAST);
    end

    always_comb begin
        state_n = state;
        hold_n  = hold_cnt;
        rst_n_n = core_rst_n;
        en_n    = 1'b0;
        busy_n  = busy;
        done_n  = done;
        to_n    = timeout;
        cnt_n   = cycle_cnt;
        unique case (state)
            HOLD: begin
                rst_n_n = 1'b0;
                if (hold_cnt == HOLD_LAST) begin
                    state_n = IDLE;
                    rst_n_n = 1'b1;
                end else begin
                    hold_n = hold_cnt + 1'b1;
                end
            end
            IDLE: begin
                if (start) begin
                    cnt_n   = '0;
                    done_n  = 1'b0;
                    to_n    = 1'b0;
                    busy_n  = 1'b1;
                    en_n    = ~step_mode;
                    state_n = step_mode ? STEP_WAIT : RUN;
                end
            end
            RUN, STEP_WAIT: begin
                if (core_en) begin
                    cnt_n = cnt_inc;
                end
                if (stop_halt || stop_wd) begin
                    state_n = HALTED;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    to_n    = stop_wd;
                end else if (state == RUN) begin
                    en_n = 1'b1;
                end else begin
                    // A step arriving during the stepped cycle is dropped.
                    en_n = step & ~core_en;
                end
            end
            HALTED: begin
                if (start) begin
                    state_n = HOLD;
                    hold_n  = HW'(1);
                    rst_n_n = 1'b0;
                end
            end
            default: begin
                state_n = HOLD;
                hold_n  = '0;
                rst_n_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Directed bench for proc_run_ctrl: reset stretch, free-run, single-step,
// watchdog, saturation, mid-run reset and restart.
module tb_proc_run_ctrl;

    logic        clk = 1'b0;
    logic        reset, start, step_mode, step, halt_in;
    logic        rn0, en0, busy0, done0, to0;
    logic [31:0] cnt0;
    logic        rn1, en1, busy1, done1, to1;
    logic [7:0]  cnt1;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    proc_run_ctrl #(.CNT_W(32), .RST_CYCLES(4), .TIMEOUT(16)) u0 (
        .clk(clk), .reset(reset), .start(start), .step_mode(step_mode),
        .step(step), .halt_in(halt_in), .core_rst_n(rn0), .core_en(en0),
        .busy(busy0), .done(done0), .timeout(to0), .cycle_cnt(cnt0)
    );

    proc_run_ctrl #(.CNT_W(8), .RST_CYCLES(4), .TIMEOUT(0)) u1 (
        .clk(clk), .reset(reset), .start(start), .step_mode(step_mode),
        .step(step), .halt_in(halt_in), .core_rst_n(rn1), .core_en(en1),
        .busy(busy1), .done(done1), .timeout(to1), .cycle_cnt(cnt1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        repeat (5) tick();
    endtask

    task automatic restart();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; step_mode = 1'b0;
        step = 1'b0; halt_in = 1'b0;

        // reset and hold stretch
        tick();
        tick();
        chk("rst_rn", rn0, 0);
        chk("rst_en", en0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_to", to0, 0);
        chk("rst_cnt", cnt0, 0);
        reset = 1'b1;
        start = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("hold_low%0d", i), rn0, 0);
            chk("hold_en", en0, 0);
        end
        start = 1'b0;
        tick();
        chk("hold_rel", rn0, 1);
        chk("idle_busy", busy0, 0);

        // halt with core_en low is ignored
        halt_in = 1'b1;
        tick();
        halt_in = 1'b0;
        chk("idle_halt", done0, 0);

        // free-run halt on 10th enabled cycle, stray start mid-run
        start = 1'b1; step_mode = 1'b0;
        tick();
        start = 1'b0;
        chk("fr_busy", busy0, 1);
        chk("fr_cnt0", cnt0, 0);
        for (int n = 1; n <= 10; n++) begin
            chk($sformatf("fr_en%0d", n), en0, 1);
            chk($sformatf("fr_cnt%0d", n), cnt0, n - 1);
            if (n == 5) start = 1'b1;
            if (n == 10) halt_in = 1'b1;
            tick();
            start = 1'b0;
        end
        halt_in = 1'b0;
        chk("fr_done", done0, 1);
        chk("fr_to", to0, 0);
        chk("fr_cnt", cnt0, 10);
        chk("fr_busy0", busy0, 0);
        chk("fr_en0", en0, 0);

        // restart from HALTED
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rs_rn0", rn0, 0);
        chk("rs_done", done0, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rs_low", rn0, 0);
        end
        tick();
        chk("rs_rel", rn0, 1);
        chk("rs_done_held", done0, 1);
        chk("rs_cnt_held", cnt0, 10);

        // single-step mode
        start = 1'b1; step_mode = 1'b1;
        tick();
        start = 1'b0; step_mode = 1'b0;
        chk("ss_done_clr", done0, 0);
        chk("ss_busy", busy0, 1);
        chk("ss_en_idle", en0, 0);
        chk("ss_cnt0", cnt0, 0);
        for (int k = 1; k <= 3; k++) begin
            step = 1'b1;
            tick();
            step = (k == 2);
            chk($sformatf("ss_pulse%0d", k), en0, 1);
            tick();
            step = 1'b0;
            chk($sformatf("ss_off%0d", k), en0, 0);
            chk($sformatf("ss_cnt%0d", k), cnt0, k);
            halt_in = (k == 1);
            for (int j = 0; j < 3; j++) begin
                tick();
                chk("ss_gap", en0, 0);
            end
            halt_in = 1'b0;
            chk("ss_nohalt", done0, 0);
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        halt_in = 1'b1;
        tick();
        halt_in = 1'b0;
        chk("ss_done", done0, 1);
        chk("ss_cnt", cnt0, 4);
        chk("ss_to", to0, 0);

        // watchdog expiry
        restart();
        chk("wd_rel", rn0, 1);
        start = 1'b1; step_mode = 1'b0;
        tick();
        start = 1'b0;
        repeat (15) tick();
        chk("wd_busy15", busy0, 1);
        chk("wd_done15", done0, 0);
        tick();
        chk("wd_done", done0, 1);
        chk("wd_to", to0, 1);
        chk("wd_cnt", cnt0, 16);
        chk("wd_en", en0, 0);

        // halt on the 16th cycle beats the watchdog
        restart();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("wd2_to_clr", to0, 0);
        repeat (15) tick();
        halt_in = 1'b1;
        tick();
        halt_in = 1'b0;
        chk("wd2_done", done0, 1);
        chk("wd2_to", to0, 0);
        chk("wd2_cnt", cnt0, 16);

        // counter saturation on the 8-bit, no-watchdog instance
        do_reset();
        chk("sat_rel", rn1, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (254) tick();
        chk("sat_254", cnt1, 254);
        repeat (46) tick();
        chk("sat_cnt", cnt1, 255);
        chk("sat_busy", busy1, 1);
        chk("sat_en", en1, 1);
        chk("sat_to", to1, 0);
        chk("sat_done", done1, 0);

        // mid-run reset
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        chk("mr_cnt6", cnt0, 6);
        chk("mr_en", en0, 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("mr_en0", en0, 0);
        chk("mr_cnt0", cnt0, 0);
        chk("mr_rn", rn0, 0);
        chk("mr_busy", busy0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
